// File: rtl/data_path_pkg.sv
// Shared constants for the Mini SRC datapath: ALU opcodes, IR field positions
// and CON condition codes.
package datapath_pkg;

   localparam logic [4:0] ALU_ADD  = 5'b00000;
   localparam logic [4:0] ALU_SUB  = 5'b00001;
   localparam logic [4:0] ALU_OR   = 5'b00010;
   localparam logic [4:0] ALU_AND  = 5'b00011;
   localparam logic [4:0] ALU_SHR  = 5'b00100;
   localparam logic [4:0] ALU_SHRA = 5'b00101;
   localparam logic [4:0] ALU_SHL  = 5'b00110;
   localparam logic [4:0] ALU_ROR  = 5'b00111;
   localparam logic [4:0] ALU_ROL  = 5'b01000;
   localparam logic [4:0] ALU_MUL  = 5'b01001;
   localparam logic [4:0] ALU_DIV  = 5'b01010;
   localparam logic [4:0] ALU_NEG  = 5'b01011;
   localparam logic [4:0] ALU_NOT  = 5'b01100;
   localparam logic [4:0] ALU_INC  = 5'b01101;

   localparam int IR_RA_HI   = 26;
   localparam int IR_RA_LO   = 23;
   localparam int IR_RB_HI   = 22;
   localparam int IR_RB_LO   = 19;
   localparam int IR_RC_HI   = 18;
   localparam int IR_RC_LO   = 15;
   localparam int IR_C_HI    = 18;
   localparam int IR_COND_HI = 20;
   localparam int IR_COND_LO = 19;

   typedef enum logic [1:0] {
      CON_ZERO    = 2'b00,
      CON_NONZERO = 2'b01,
      CON_POS     = 2'b10,
      CON_NEG     = 2'b11
   } con_cond_e;

endpackage

// File: rtl/data_path_if.sv
// Control-unit <-> datapath bundle: one-hot bus/load strobes in, register taps out.
// R_out[n] / R_en[n] carry the per-register R<n>out / R<n>en strobes.
interface data_path_if #(parameter int WIDTH = 32);
   logic [4:0]       alu_control;
   logic [WIDTH-1:0] Mdatain;
   logic [15:0]      R_out;
   logic [15:0]      R_en;
   logic             MDROut, HIout, LOout, ZHIout, ZLOout, Pout, Cout, Yout;
   logic             IRen, MARen, MDRen, Read, Write;
   logic             Yen, Pen, ZHIen, ZLOen, HIen, LOen;
   logic             Gra, Grb, Grc, BAout, ConIn, Rin, Rout;
   logic [WIDTH-1:0] bus_q, ir_q, mar_q, mdr_q;
   logic             mem_write, con_q;

   modport master (
      output alu_control, Mdatain, R_out, R_en,
      output MDROut, HIout, LOout, ZHIout, ZLOout, Pout, Cout, Yout,
      output IRen, MARen, MDRen, Read, Write,
      output Yen, Pen, ZHIen, ZLOen, HIen, LOen,
      output Gra, Grb, Grc, BAout, ConIn, Rin, Rout,
      input  bus_q, ir_q, mar_q, mdr_q, mem_write, con_q
   );

   modport slave (
      input  alu_control, Mdatain, R_out, R_en,
      input  MDROut, HIout, LOout, ZHIout, ZLOout, Pout, Cout, Yout,
      input  IRen, MARen, MDRen, Read, Write,
      input  Yen, Pen, ZHIen, ZLOen, HIen, LOen,
      input  Gra, Grb, Grc, BAout, ConIn, Rin, Rout,
      output bus_q, ir_q, mar_q, mdr_q, mem_write, con_q
   );
endinterface

// File: rtl/data_path_alu.sv
// Combinational ALU: A = Y, B = bus, 64-bit result feeding ZHI/ZLO.
// MUL/DIV hardware exists only when DATAPATH_MULDIV_EN is defined.
module data_path_alu
   import datapath_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic [4:0]         op,
   output logic [2*WIDTH-1:0] result
);

   logic [4:0]         sh;
   logic [2*WIDTH-1:0] rot_r, rot_l;

   assign sh    = b[4:0];
   // Rotates fall out of shifting the doubled word.
   assign rot_r = {a, a} >> sh;
   assign rot_l = {a, a} << sh;

`ifdef DATAPATH_MULDIV_EN
   logic signed [2*WIDTH-1:0] a_ext, b_ext, prod, quot, rem;
   logic                      unused_div_hi;

   // 64-bit operands keep the most-negative / -1 quotient well defined.
   assign a_ext = {{WIDTH{a[WIDTH-1]}}, a};
   assign b_ext = {{WIDTH{b[WIDTH-1]}}, b};
   assign prod  = a_ext * b_ext;
   assign quot  = (b == '0) ? '0 : a_ext / b_ext;
   assign rem   = (b == '0) ? '0 : a_ext % b_ext;
   assign unused_div_hi = &{1'b0, quot[2*WIDTH-1:WIDTH], rem[2*WIDTH-1:WIDTH]};
`endif

   always_comb begin
      result = '0;
      case (op)
         ALU_ADD:  result[WIDTH-1:0] = a + b;
         ALU_SUB:  result[WIDTH-1:0] = a - b;
         ALU_OR:   result[WIDTH-1:0] = a | b;
         ALU_AND:  result[WIDTH-1:0] = a & b;
         ALU_SHR:  result[WIDTH-1:0] = a >> sh;
         ALU_SHRA: result[WIDTH-1:0] = $signed(a) >>> sh;
         ALU_SHL:  result[WIDTH-1:0] = a << sh;
         ALU_ROR:  result[WIDTH-1:0] = rot_r[WIDTH-1:0];
         ALU_ROL:  result[WIDTH-1:0] = rot_l[2*WIDTH-1:WIDTH];
`ifdef DATAPATH_MULDIV_EN
         ALU_MUL:  result = prod;
         ALU_DIV:  result = {rem[WIDTH-1:0], quot[WIDTH-1:0]};
`else
         ALU_MUL, ALU_DIV: result = '0;
`endif
         ALU_NEG:  result[WIDTH-1:0] = '0 - b;
         ALU_NOT:  result[WIDTH-1:0] = ~b;
         ALU_INC:  result[WIDTH-1:0] = b + {{(WIDTH-1){1'b0}}, 1'b1};
         default:  result[WIDTH-1:0] = b;
      endcase
   end

endmodule

// File: rtl/data_path.sv
// Mini SRC single-bus datapath: register file, special registers, bus mux,
// select-and-encode and CON. Optional MUL/DIV via DATAPATH_MULDIV_EN.
module data_path
   import datapath_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic      clk,
   input  logic      clr,
   data_path_if.slave dp
);

   localparam int NREG = 16;

   logic [WIDTH-1:0]   r_reg [NREG];
   logic [WIDTH-1:0]   r_rd  [NREG];
   logic [WIDTH-1:0]   pc_reg, ir_reg, mar_reg, mdr_reg, y_reg, hi_reg, lo_reg;
   logic [WIDTH-1:0]   zhi_reg, zlo_reg;
   logic               con_reg, con_next;
   logic [WIDTH-1:0]   bus_value, c_ext;
   logic [2*WIDTH-1:0] alu_result;
   logic [3:0]         ra, rb, rc, sel_idx;
   logic [NREG-1:0]    sel, r_load, r_drive;

   assign ra      = ir_reg[IR_RA_HI:IR_RA_LO];
   assign rb      = ir_reg[IR_RB_HI:IR_RB_LO];
   assign rc      = ir_reg[IR_RC_HI:IR_RC_LO];
   assign sel_idx = ({4{dp.Gra}} & ra) | ({4{dp.Grb}} & rb) | ({4{dp.Grc}} & rc);
   assign sel     = 16'b1 << sel_idx;
   assign c_ext   = {{(WIDTH-IR_C_HI-1){ir_reg[IR_C_HI]}}, ir_reg[IR_C_HI:0]};

   generate
      for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
         assign r_load[gi]  = dp.R_en[gi] | (dp.Rin & sel[gi]);
         assign r_drive[gi] = dp.R_out[gi] | ((dp.Rout | dp.BAout) & sel[gi]);
         if (gi == 0) begin : g_r0
            // Base-address reads treat R0 as a hard zero.
            assign r_rd[gi] = (dp.BAout & sel[0]) ? '0 : r_reg[gi];
         end else begin : g_rn
            assign r_rd[gi] = r_reg[gi];
         end
      end
   endgenerate

   // Lowest-priority source first so higher-priority ones overwrite it.
   always_comb begin
      bus_value = '0;
      if (dp.Yout)   bus_value = y_reg;
      if (dp.Cout)   bus_value = c_ext;
      if (dp.MDROut) bus_value = mdr_reg;
      if (dp.Pout)   bus_value = pc_reg;
      if (dp.ZLOout) bus_value = zlo_reg;
      if (dp.ZHIout) bus_value = zhi_reg;
      if (dp.LOout)  bus_value = lo_reg;
      if (dp.HIout)  bus_value = hi_reg;
      for (int i = NREG - 1; i >= 0; i--) begin
         if (r_drive[i]) bus_value = r_rd[i];
      end
   end

   always_comb begin
      con_next = 1'b0;
      case (con_cond_e'(ir_reg[IR_COND_HI:IR_COND_LO]))
         CON_ZERO:    con_next = (bus_value == '0);
         CON_NONZERO: con_next = (bus_value != '0);
         CON_POS:     con_next = !bus_value[WIDTH-1] && (bus_value != '0);
         CON_NEG:     con_next = bus_value[WIDTH-1];
         default:     con_next = 1'b0;
      endcase
   end

   data_path_alu #(.WIDTH(WIDTH)) u_alu (
      .a      (y_reg),
      .b      (bus_value),
      .op     (dp.alu_control),
      .result (alu_result)
   );

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         for (int i = 0; i < NREG; i++) r_reg[i] <= '0;
         pc_reg  <= '0;
         ir_reg  <= '0;
         mar_reg <= '0;
         mdr_reg <= '0;
         y_reg   <= '0;
         hi_reg  <= '0;
         lo_reg  <= '0;
         zhi_reg <= '0;
         zlo_reg <= '0;
         con_reg <= 1'b0;
      end else begin
         for (int i = 0; i < NREG; i++) begin
            if (r_load[i]) r_reg[i] <= bus_value;
         end
         if (dp.Pen)   pc_reg  <= bus_value;
         if (dp.IRen)  ir_reg  <= bus_value;
         if (dp.MARen) mar_reg <= bus_value;
         if (dp.MDRen) mdr_reg <= dp.Read ? dp.Mdatain : bus_value;
         if (dp.Yen)   y_reg   <= bus_value;
         if (dp.HIen)  hi_reg  <= bus_value;
         if (dp.LOen)  lo_reg  <= bus_value;
         if (dp.ZHIen) zhi_reg <= alu_result[2*WIDTH-1:WIDTH];
         if (dp.ZLOen) zlo_reg <= alu_result[WIDTH-1:0];
         if (dp.ConIn) con_reg <= con_next;
      end
   end

   assign dp.bus_q     = bus_value;
   assign dp.ir_q      = ir_reg;
   assign dp.mar_q     = mar_reg;
   assign dp.mdr_q     = mdr_reg;
   assign dp.mem_write = dp.Write;
   assign dp.con_q     = con_reg;

endmodule

// File: tb/tb_data_path.sv
// Self-checking bench for data_path: directed steps followed by random control
// patterns, all checked against a behavioural model of the register machine.
module tb_data_path;

   logic clk = 1'b0;
   logic clr;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   data_path_if d ();

   data_path dut (.clk(clk), .clr(clr), .dp(d));

`ifdef DATAPATH_MULDIV_EN
   localparam logic [31:0] EXP_MUL_HI = 32'hFFFFFFFF, EXP_MUL_LO = 32'hFFFFFFFA;
   localparam logic [31:0] EXP_DIV_HI = 32'h00000001, EXP_DIV_LO = 32'hFFFFFFFD;
`else
   localparam logic [31:0] EXP_MUL_HI = 32'h0, EXP_MUL_LO = 32'h0;
   localparam logic [31:0] EXP_DIV_HI = 32'h0, EXP_DIV_LO = 32'h0;
`endif

   // Behavioural model state
   logic [31:0] m_r [16];
   logic [31:0] m_pc, m_ir, m_mar, m_mdr, m_y, m_hi, m_lo, m_zhi, m_zlo;
   logic        m_con;

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_r[i] = 32'h0;
      m_pc = 0; m_ir = 0; m_mar = 0; m_mdr = 0; m_y = 0;
      m_hi = 0; m_lo = 0; m_zhi = 0; m_zlo = 0; m_con = 1'b0;
   endtask

   task automatic clear_ctl();
      d.alu_control = 5'd0; d.Mdatain = 32'h0; d.R_out = 16'h0; d.R_en = 16'h0;
      d.MDROut = 0; d.HIout = 0; d.LOout = 0; d.ZHIout = 0; d.ZLOout = 0;
      d.Pout = 0; d.Cout = 0; d.Yout = 0;
      d.IRen = 0; d.MARen = 0; d.MDRen = 0; d.Read = 0; d.Write = 0;
      d.Yen = 0; d.Pen = 0; d.ZHIen = 0; d.ZLOen = 0; d.HIen = 0; d.LOen = 0;
      d.Gra = 0; d.Grb = 0; d.Grc = 0; d.BAout = 0; d.ConIn = 0; d.Rin = 0; d.Rout = 0;
   endtask

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Register number named by the Gra/Grb/Grc fields of the model IR
   function automatic int sel_of();
      int s = 0;
      if (d.Gra) s = s | int'(m_ir[26:23]);
      if (d.Grb) s = s | int'(m_ir[22:19]);
      if (d.Grc) s = s | int'(m_ir[18:15]);
      return s;
   endfunction

   function automatic logic [31:0] c_value();
      int v = int'(m_ir[18:0]);
      if (m_ir[18]) v = v - (1 << 19);
      return 32'(v);
   endfunction

   function automatic logic [31:0] ref_bus();
      int s = sel_of();
      for (int n = 0; n < 16; n++) begin
         if (d.R_out[n] || ((d.Rout || d.BAout) && n == s))
            return (n == 0 && d.BAout && s == 0) ? 32'h0 : m_r[n];
      end
      if (d.HIout)  return m_hi;
      if (d.LOout)  return m_lo;
      if (d.ZHIout) return m_zhi;
      if (d.ZLOout) return m_zlo;
      if (d.Pout)   return m_pc;
      if (d.MDROut) return m_mdr;
      if (d.Cout)   return c_value();
      if (d.Yout)   return m_y;
      return 32'h0;
   endfunction

   function automatic logic [63:0] ref_alu(logic [4:0] op, logic [31:0] a, logic [31:0] b);
      logic [31:0] v = a;
      int          sh = int'(b[4:0]);
      longint      sa = longint'($signed(a));
      longint      sb = longint'($signed(b));
      case (op)
         5'd0:  return {32'h0, a + b};
         5'd1:  return {32'h0, a - b};
         5'd2:  return {32'h0, a | b};
         5'd3:  return {32'h0, a & b};
         5'd4:  begin repeat (sh) v = v / 2;            return {32'h0, v}; end
         5'd5:  begin repeat (sh) v = {v[31], v[31:1]}; return {32'h0, v}; end
         5'd6:  begin repeat (sh) v = v * 2;            return {32'h0, v}; end
         5'd7:  begin repeat (sh) v = {v[0], v[31:1]};  return {32'h0, v}; end
         5'd8:  begin repeat (sh) v = {v[30:0], v[31]}; return {32'h0, v}; end
`ifdef DATAPATH_MULDIV_EN
         5'd9:  return 64'(sa * sb);
         5'd10: begin
            if (b == 32'h0) return 64'h0;
            return {32'(sa % sb), 32'(sa / sb)};
         end
`else
         5'd9, 5'd10: return 64'h0;
`endif
         5'd11: return {32'h0, 32'h0 - b};
         5'd12: return {32'h0, ~b};
         5'd13: return {32'h0, b + 32'h1};
         default: return {32'h0, b};
      endcase
   endfunction

   // One clock: check outputs against the model, advance the model, cross the edge.
   task automatic step();
      logic [31:0] bus_m;
      logic [63:0] z_m;
      logic        con_m;
      int          s;
      #1;
      bus_m = ref_bus();
      check("bus", d.bus_q, bus_m);
      check("ir", d.ir_q, m_ir);
      check("mar", d.mar_q, m_mar);
      check("mdr", d.mdr_q, m_mdr);
      check("con", {31'h0, d.con_q}, {31'h0, m_con});
      check("mem_write", {31'h0, d.mem_write}, {31'h0, d.Write});
      if (clr) begin
         s = sel_of();
         z_m = ref_alu(d.alu_control, m_y, bus_m);
         case (m_ir[20:19])
            2'b00:   con_m = (bus_m == 0);
            2'b01:   con_m = (bus_m != 0);
            2'b10:   con_m = !bus_m[31] && bus_m != 0;
            default: con_m = bus_m[31];
         endcase
         for (int n = 0; n < 16; n++)
            if (d.R_en[n] || (d.Rin && n == s)) m_r[n] = bus_m;
         if (d.Pen)   m_pc  = bus_m;
         if (d.IRen)  m_ir  = bus_m;
         if (d.MARen) m_mar = bus_m;
         if (d.MDRen) m_mdr = d.Read ? d.Mdatain : bus_m;
         if (d.Yen)   m_y   = bus_m;
         if (d.HIen)  m_hi  = bus_m;
         if (d.LOen)  m_lo  = bus_m;
         if (d.ZHIen) m_zhi = z_m[63:32];
         if (d.ZLOen) m_zlo = z_m[31:0];
         if (d.ConIn) m_con = con_m;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic peek(string tag, logic [31:0] exp);
      #1;
      check(tag, d.bus_q, exp);
   endtask

   task automatic load_via_mdr(logic [31:0] v);
      clear_ctl();
      d.Mdatain = v; d.Read = 1; d.MDRen = 1;
      step();
      clear_ctl();
   endtask

   task automatic rand_ctl();
      int pick;
      clear_ctl();
      d.alu_control = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(14, 31))
                                                  : 5'($urandom_range(0, 13));
      d.Mdatain = $urandom;
      d.Read    = 1'($urandom_range(0, 1));
      d.Write   = 1'($urandom_range(0, 1));
      d.Gra = 1'($urandom_range(0, 1)); d.Grb = 1'($urandom_range(0, 1));
      d.Grc = 1'($urandom_range(0, 1));
      pick = $urandom_range(0, 27);
      if (pick < 16) d.R_out[pick] = 1'b1;
      case (pick)
         16: d.HIout = 1;  17: d.LOout = 1;  18: d.ZHIout = 1; 19: d.ZLOout = 1;
         20: d.Pout = 1;   21: d.MDROut = 1; 22: d.Cout = 1;   23: d.Yout = 1;
         25: begin
            d.R_out = 16'($urandom & $urandom);
            d.HIout = 1'($urandom_range(0, 1)); d.ZLOout = 1'($urandom_range(0, 1));
            d.MDROut = 1; d.Yout = 1;
         end
         26: d.Rout = 1;
         27: d.BAout = 1;
         default: ;
      endcase
      d.R_en  = 16'($urandom & $urandom & $urandom);
      d.Rin   = ($urandom_range(0, 3) == 0);
      d.IRen  = ($urandom_range(0, 3) == 0);
      d.MARen = ($urandom_range(0, 3) == 0);
      d.MDRen = ($urandom_range(0, 2) == 0);
      d.Yen   = ($urandom_range(0, 2) == 0);
      d.Pen   = ($urandom_range(0, 3) == 0);
      d.HIen  = ($urandom_range(0, 3) == 0);
      d.LOen  = ($urandom_range(0, 3) == 0);
      d.ZHIen = ($urandom_range(0, 1) == 0);
      d.ZLOen = ($urandom_range(0, 1) == 0);
      d.ConIn = ($urandom_range(0, 2) == 0);
   endtask

   initial begin
      clr = 1'b0;
      clear_ctl();
      model_reset();
      @(negedge clk);
      @(negedge clk);
      clr = 1'b1;

      // Reset mid-cycle after some registers hold data
      load_via_mdr(32'hDEADBEEF);
      d.MDROut = 1; d.IRen = 1; d.Yen = 1; d.MARen = 1;
      step();
      clear_ctl();
      d.Mdatain = 32'hA5A5A5A5; d.Read = 1; d.MDRen = 1; d.Yout = 1;
      #2;
      clr = 1'b0;
      model_reset();
      #1;
      check("rst_mdr", d.mdr_q, 32'h0);
      check("rst_ir", d.ir_q, 32'h0);
      check("rst_mar", d.mar_q, 32'h0);
      check("rst_bus_y", d.bus_q, 32'h0);
      check("rst_con", {31'h0, d.con_q}, 32'h0);
      @(posedge clk);
      #1;
      check("rst_hold_mdr", d.mdr_q, 32'h0);
      @(negedge clk);
      clr = 1'b1;
      clear_ctl();

      // Load path: memory -> MDR -> R2
      load_via_mdr(32'h12345678);
      check("mdr_load", d.mdr_q, 32'h12345678);
      d.MDROut = 1; d.R_en[2] = 1;
      step();
      clear_ctl(); d.R_out[2] = 1;
      peek("r2_read", 32'h12345678);
      step();

      // andi R1,R2,0xF
      load_via_mdr(32'h0090000F);
      d.MDROut = 1; d.IRen = 1;
      step();
      check("ir_andi", d.ir_q, 32'h0090000F);
      clear_ctl(); d.Grb = 1; d.Rout = 1; d.Yen = 1;
      peek("grb_rout", 32'h12345678);
      step();
      clear_ctl(); d.Cout = 1; d.alu_control = 5'b00011; d.ZLOen = 1;
      peek("c_andi", 32'h0000000F);
      step();
      clear_ctl(); d.ZLOout = 1; d.Gra = 1; d.Rin = 1;
      peek("zlo_andi", 32'h00000008);
      step();
      clear_ctl(); d.R_out[1] = 1;
      peek("r1_andi", 32'h00000008);
      step();

      // Read-while-load sees the old value
      clear_ctl(); d.R_out[1] = 1; d.R_en[1] = 1; d.Pen = 1;
      step();

      // Sign extension of the constant field
      load_via_mdr(32'h00040000);
      d.MDROut = 1; d.IRen = 1;
      step();
      clear_ctl(); d.Cout = 1;
      peek("c_sext", 32'hFFFC0000);
      d.ConIn = 1;
      step();
      check("con_nonzero_bus", {31'h0, d.con_q}, 32'h0);

      // CON with bus==0
      clear_ctl(); d.ConIn = 1;
      step();
      check("con_zero_bus", {31'h0, d.con_q}, 32'h1);

      // BAout forces zero for R0
      load_via_mdr(32'h5);
      d.MDROut = 1; d.R_en[0] = 1;
      step();
      clear_ctl(); d.Gra = 1; d.BAout = 1;
      peek("baout_r0", 32'h0);
      step();
      clear_ctl(); d.Gra = 1; d.Rout = 1;
      peek("rout_r0", 32'h5);
      step();

      // Priority: R3 wins over HI and Y
      clear_ctl(); d.R_out[3] = 1; d.HIout = 1; d.Yout = 1;
      step();

      // MUL
      load_via_mdr(32'hFFFFFFFE);
      d.MDROut = 1; d.Yen = 1;
      step();
      load_via_mdr(32'h3);
      d.MDROut = 1; d.alu_control = 5'b01001; d.ZHIen = 1; d.ZLOen = 1;
      step();
      clear_ctl(); d.ZHIout = 1;
      peek("mul_hi", EXP_MUL_HI);
      step();
      clear_ctl(); d.ZLOout = 1;
      peek("mul_lo", EXP_MUL_LO);
      step();

      // DIV
      load_via_mdr(32'h7);
      d.MDROut = 1; d.Yen = 1;
      step();
      load_via_mdr(32'hFFFFFFFE);
      d.MDROut = 1; d.alu_control = 5'b01010; d.ZHIen = 1; d.ZLOen = 1;
      step();
      clear_ctl(); d.ZHIout = 1;
      peek("div_hi", EXP_DIV_HI);
      step();
      clear_ctl(); d.ZLOout = 1;
      peek("div_lo", EXP_DIV_LO);
      step();

      // DIV by zero clears Z
      clear_ctl(); d.alu_control = 5'b01010; d.ZHIen = 1; d.ZLOen = 1;
      step();
      clear_ctl(); d.ZHIout = 1;
      peek("div0_hi", 32'h0);
      step();
      clear_ctl(); d.ZLOout = 1;
      peek("div0_lo", 32'h0);
      step();

      // Random control patterns against the model
      for (int k = 0; k < 600; k++) begin
         rand_ctl();
         step();
      end
      clear_ctl();
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/data_path.md
Name: data_path

Overview:
- 32-bit single-bus datapath for the Mini SRC processor.
- Contains:
  - 16 general registers R0–R15
  - PC, IR, MAR, MDR, Y, HI, LO
  - 64-bit Z (ZHI/ZLO)
  - CON flip-flop
  - ALU
- An external control unit drives one-hot enable/out strobes each clock; one source drives the shared bus per cycle.
- Memory sits outside; data enters via Mdatain, and MAR/MDR/Write are exported.

Parameters:
- WIDTH, 32, datapath word width (fixed at 32; parameter for readability only).

Ports:
- clk in 1: clock, rising edge.
- clr in 1: asynchronous active-low reset.
- alu_control in 5: ALU opcode.
- Mdatain in 32: memory read data.
- R0out..R15out in 1 each: drive Rn onto bus.
- MDROut, HIout, LOout, ZHIout, ZLOout, Pout, Cout, Yout in 1 each: drive MDR/HI/LO/Z[63:32]/Z[31:0]/PC/C-sign-ext/Y onto bus.
- IRen, MARen, MDRen in 1 each: load strobes.
- Read in 1: MDR input mux selects Mdatain when 1, bus when 0.
- Write in 1: memory write request, passed to mem_write.
- Yen, Pen, ZHIen, ZLOen, HIen, LOen in 1 each: load strobes.
- R0en..R15en in 1 each: load Rn from bus.
- Gra, Grb, Grc, BAout, ConIn, Rin, Rout in 1 each: select-and-encode controls.
- bus_q out 32: current bus value.
- ir_q, mar_q, mdr_q out 32: register contents.
- mem_write out 1: equals Write, combinational.
- con_q out 1: CON flip-flop.

Behaviour:
- Reset: clr=0 asynchronously clears all registers and CON to 0. All outputs derived from registers are therefore 0.
- Loads: every register loads on the rising clk edge when its enable is 1.
  - Source is the bus, except MDR, which takes Mdatain when Read=1.
  - Load latency 1 cycle; bus and ALU are combinational.
- IR fields:
  - Ra = IR[26:23], Rb = IR[22:19], Rc = IR[18:15].
  - C = sign-extend(IR[18:0]) to 32 bits.
  - Select = (Gra & Ra) | (Grb & Rb) | (Grc & Rc), decoded to one-hot 16.
- Register enables:
  - Rn enable = Rnen | (Rin & sel[n]).
  - Rn out = Rnout | ((Rout | BAout) & sel[n]).
- BAout: when BAout selects R0, the bus gets 0 instead of R0.
- Bus mux:
  - One source is expected.
  - If several are asserted, priority is R0..R15, HI, LO, ZHI, ZLO, PC, MDR, C, Y.
  - No source drives 0.
- ALU: A = Y, B = bus. Result is 64 bits into Z; ZLOen loads Z[31:0] and ZHIen loads Z[63:32]. Non-MUL/DIV ops put 0 in the high half.

| Code | Op | Result |
|---|---|---|
| 00000 | ADD | A+B |
| 00001 | SUB | A−B |
| 00010 | OR | A\|B |
| 00011 | AND | A&B |
| 00100 | SHR | logical, amount B[4:0] |
| 00101 | SHRA | arithmetic, amount B[4:0] |
| 00110 | SHL | amount B[4:0] |
| 00111 | ROR | amount B[4:0] |
| 01000 | ROL | amount B[4:0] |
| 01001 | MUL | signed 32×32→64 |
| 01010 | DIV | signed; lo = quotient truncated toward zero, hi = remainder with sign of A; B=0 gives Z=0 |
| 01011 | NEG | −B |
| 01100 | NOT | ~B |
| 01101 | INC | B+1 (PC increment) |
| others | — | B |

- Adds/subtracts wrap modulo 2^32.
- CON: on an edge with ConIn=1, CON loads the condition below, evaluated on the bus:

| IR[20:19] | Condition |
|---|---|
| 00 | bus==0 |
| 01 | bus!=0 |
| 10 | bus[31]==0 && bus!=0 |
| 11 | bus[31]==1 |

- Simultaneous load and read of the same register: the read sees the old value, and the new value appears next cycle.

Optional Feature:
- DATAPATH_MULDIV_EN
  - Defined: MUL and DIV are implemented as above.
  - Undefined: codes 01001/01010 produce Z=0 and no multiplier/divider logic is synthesized.

Decomposition:
- Package datapath_pkg holds:
  - ALU opcode localparams (ALU_ADD..ALU_INC)
  - IR field bit-position constants
  - CON condition codes
- One sub-module, data_path_alu: combinational A, B, opcode → 64-bit result.
- Register file, bus mux, select-and-encode and CON stay in data_path.

Test Plan:
- Reset: drive clr=0 mid-cycle with MDRen=1 → all registers, bus_q and con_q read 0 immediately; loads are ignored until clr=1.
- Load path: Mdatain=0x12345678, Read=1, MDRen=1; next cycle MDROut=1, R2en=1 → R2=0x12345678 and mdr_q=0x12345678.
- andi R1,R2,0xF with R2=0x12345678:
  - Setup: IR=0x0090000F (via MDR→IR).
  - Grb+Rout+Yen → Y=0x12345678.
  - Cout with alu_control=00011 and ZLOen → ZLO=0x00000008.
  - ZLOout+Gra+Rin → R1=0x00000008.
- Sign extension: IR[18:0]=0x40000, Cout → bus_q=0xFFFC0000.
- MUL/DIV (macro defined):
  - Y=0xFFFFFFFE, bus=3, MUL → ZHI=0xFFFFFFFF, ZLO=0xFFFFFFFA.
  - Y=7, bus=0xFFFFFFFE, DIV → ZLO=0xFFFFFFFD, ZHI=1.
- CON and BAout:
  - IR[20:19]=00, bus=0, ConIn → con_q=1.
  - With Ra=0, R0=5, Gra+BAout → bus_q=0.
